// File: rtl/nco_pkg.sv
// Shared types and default sizing for the time-shared NCO channel scheduler.
// The tag struct is sized here, so the channel count used by the RTL must
// match NCO_NUM_CH.
package nco_pkg;

  localparam int NCO_NUM_CH      = 4;
  localparam int NCO_PHASE_WIDTH = 32;
  localparam int NCO_QLUT_DEPTH  = 11;
  localparam int NCO_DATA_WIDTH  = 16;
  localparam int NCO_LUT_LATENCY = 3;

  localparam int CH_W = $clog2(NCO_NUM_CH);

  // Meaning of the cfg_sel field on the configuration port.
  typedef enum logic [1:0] {
    CFG_FREQ = 2'd0,
    CFG_OFFS = 2'd1,
    CFG_CLR  = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_t;

  // Travels alongside a theta through the external LUT pipeline so the
  // returned sample can be attributed to its channel.
  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } nco_tag_t;

endpackage

// File: rtl/nco_tag_pipe.sv
// Delay line for channel tags. Its depth equals the sine_cosine pipeline
// depth, so a tag leaves exactly when the matching sin/cos sample arrives.
module nco_tag_pipe
  import nco_pkg::*;
#(
  parameter int DEPTH = NCO_LUT_LATENCY
) (
  input  logic     clk,
  input  logic     arst,
  input  nco_tag_t tag_in,
  output nco_tag_t tag_out
);

  nco_tag_t stage_q [DEPTH];

  // Shift tags one stage per clock; reset empties every stage.
  always_ff @(posedge clk) begin
    if (arst) begin
      // NOTE: every stage is reset (not just the valid bits of a few). A
      // stale valid tag left behind a reset would emit a phantom sample.
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's
      // old value, which is what makes this a shift register rather than a
      // single wire.
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/nco_channel_scheduler.sv
// Time-shares one sine_cosine LUT among NUM_CH NCO channels. One slot per
// clock in a fixed round-robin frame: the slot's channel (if enabled) sends
// its phase to the LUT and advances its accumulator. The returned samples
// are re-tagged with their channel and registered on the output.
module nco_channel_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_CH      = NCO_NUM_CH,
  parameter int PHASE_WIDTH = NCO_PHASE_WIDTH,
  parameter int QLUT_DEPTH  = NCO_QLUT_DEPTH,
  parameter int DATA_WIDTH  = NCO_DATA_WIDTH,
  parameter int LUT_LATENCY = NCO_LUT_LATENCY
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [1:0]                   cfg_sel,
  input  logic [PHASE_WIDTH-1:0]       cfg_data,
  output logic [QLUT_DEPTH-1:0]        theta,
  input  logic signed [DATA_WIDTH-1:0] sin_in,
  input  logic signed [DATA_WIDTH-1:0] cos_in,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [DATA_WIDTH-1:0] out_sin,
  output logic signed [DATA_WIDTH-1:0] out_cos,
  output logic                         frame_sync
);

  localparam int THETA_SHIFT = PHASE_WIDTH - QLUT_DEPTH;

  // Slot pointer of the TDM frame.
  logic [CH_W-1:0]        slot_q;

  // Per-channel NCO state and configuration.
  logic [PHASE_WIDTH-1:0] acc_q  [NUM_CH];
  logic [PHASE_WIDTH-1:0] freq_q [NUM_CH];
  logic [PHASE_WIDTH-1:0] off_q  [NUM_CH];

  // Issue-side decode.
  logic                   issue;
  logic [PHASE_WIDTH-1:0] phase_sum;
  nco_tag_t               issue_tag;
  cfg_sel_t               cfg_op;
  logic                   cfg_clr;

  // Tag registered together with theta, and the tag leaving the delay line
  // in step with sin_in/cos_in.
  nco_tag_t               tag_q;
  nco_tag_t               lut_tag;

  // Decode the current slot and the config strobe.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition,
    // so no path leaves one unassigned and no latch is inferred.
    issue           = 1'b0;
    phase_sum       = '0;
    issue_tag       = '0;
    cfg_op          = cfg_sel_t'(cfg_sel);
    cfg_clr         = 1'b0;

    issue           = enable && ch_en[slot_q];
    phase_sum       = acc_q[slot_q] + off_q[slot_q];
    issue_tag.valid = issue;
    issue_tag.ch    = slot_q;
    cfg_clr         = cfg_we && (cfg_op == CFG_CLR);
  end

  // Slot counter: advances while running, holds while stopped. NUM_CH is a
  // power of two, so the natural wrap of the counter closes the frame.
  always_ff @(posedge clk) begin
    if (arst) begin
      slot_q <= '0;
    end else if (enable) begin
      slot_q <= slot_q + CH_W'(1);
    end
  end

  // Frequency and phase-offset registers, written from the config port.
  // A write lands on the next edge, so an issue in the same cycle still
  // sees the old value.
  always_ff @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq_q[i] <= '0;
        off_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      case (cfg_op)
        CFG_FREQ: freq_q[cfg_ch] <= cfg_data;
        CFG_OFFS: off_q[cfg_ch]  <= cfg_data;
        default:  ;
      endcase
    end
  end

  // Phase accumulators: the issued channel advances by its frequency word;
  // a clear to the same channel in the same cycle overrides the advance
  // because it is the later assignment.
  always_ff @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      if (issue) begin
        acc_q[slot_q] <= acc_q[slot_q] + freq_q[slot_q];
      end
      if (cfg_clr) begin
        acc_q[cfg_ch] <= '0;
      end
    end
  end

  // Issue register: theta (uses the pre-advance accumulator), its tag and
  // the start-of-frame marker. theta holds across bubbles.
  always_ff @(posedge clk) begin
    if (arst) begin
      theta      <= '0;
      tag_q      <= '0;
      frame_sync <= 1'b0;
    end else begin
      tag_q      <= issue_tag;
      frame_sync <= issue && (slot_q == '0);
      if (issue) begin
        theta <= QLUT_DEPTH'(phase_sum >> THETA_SHIFT);
      end
    end
  end

  // Delay the tag by the LUT depth so it meets its own sample.
  nco_tag_pipe #(
    .DEPTH (LUT_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .arst    (arst),
    .tag_in  (tag_q),
    .tag_out (lut_tag)
  );

  // Output register: capture the sample only when its tag is valid, so the
  // mixer sees the last real sample held through bubbles.
  always_ff @(posedge clk) begin
    if (arst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sin   <= '0;
      out_cos   <= '0;
    end else begin
      out_valid <= lut_tag.valid;
      out_ch    <= lut_tag.ch;
      if (lut_tag.valid) begin
        out_sin <= sin_in;
        out_cos <= cos_in;
      end
    end
  end

endmodule

// File: tb/tb_nco_channel_scheduler.sv
// Self-checking bench for nco_channel_scheduler. A behavioural sine_cosine
// LUT with three clocks of latency sits on theta/sin_in/cos_in. A reference
// model of the scheduler pushes one expected output per clock into a
// scoreboard; the monitor pops and compares once the pipeline delay has
// elapsed. Directed sequences add explicit checks on hand-derived values.
module tb_nco_channel_scheduler;
  import nco_pkg::*;

  localparam int NCH   = NCO_NUM_CH;
  localparam int PW    = NCO_PHASE_WIDTH;
  localparam int QD    = NCO_QLUT_DEPTH;
  localparam int DW    = NCO_DATA_WIDTH;
  localparam int SHIFT = PW - QD;
  // Entries between a model push and its output: theta reg, LUT_LATENCY
  // tag stages, output reg.
  localparam int SB_DEPTH = NCO_LUT_LATENCY + 2;

  logic                 clk;
  logic                 arst;
  logic                 enable;
  logic [NCH-1:0]       ch_en;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_sel;
  logic [PW-1:0]        cfg_data;
  logic [QD-1:0]        theta;
  logic signed [DW-1:0] sin_in;
  logic signed [DW-1:0] cos_in;
  logic                 out_valid;
  logic [CH_W-1:0]      out_ch;
  logic signed [DW-1:0] out_sin;
  logic signed [DW-1:0] out_cos;
  logic                 frame_sync;

  int n_cmp = 0;
  int n_mis = 0;

  nco_channel_scheduler dut (
    .clk        (clk),
    .arst       (arst),
    .enable     (enable),
    .ch_en      (ch_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .theta      (theta),
    .sin_in     (sin_in),
    .cos_in     (cos_in),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_sin    (out_sin),
    .out_cos    (out_cos),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- golden sine_cosine LUT ----------------
  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  function automatic logic [DW-1:0] lut_sin(input logic [QD-1:0] th);
    real a;
    a = 6.283185307179586 * real'(th) / real'(1 << QD);
    return DW'(rnd(32767.0 * $sin(a)));
  endfunction

  function automatic logic [DW-1:0] lut_cos(input logic [QD-1:0] th);
    real a;
    a = 6.283185307179586 * real'(th) / real'(1 << QD);
    return DW'(rnd(32767.0 * $cos(a)));
  endfunction

  logic [QD-1:0] lut_d1, lut_d2;
  always @(posedge clk) begin
    lut_d1 <= theta;
    lut_d2 <= lut_d1;
    sin_in <= lut_sin(lut_d2);
    cos_in <= lut_cos(lut_d2);
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic            clr;
    logic            valid;
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   s;
    logic [DW-1:0]   c;
  } exp_t;

  exp_t          sb_q [$];
  logic [PW-1:0] m_acc  [NCH];
  logic [PW-1:0] m_freq [NCH];
  logic [PW-1:0] m_off  [NCH];
  logic [CH_W-1:0] m_slot;
  logic [QD-1:0] m_theta;
  logic          m_fs;
  logic          m_live = 1'b0;

  always @(posedge clk) begin : model
    exp_t          e;
    logic          iss;
    logic [PW-1:0] sum;
    m_live = 1'b1;
    if (arst) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = '0; m_freq[i] = '0; m_off[i] = '0;
      end
      m_slot  = '0;
      m_theta = '0;
      m_fs    = 1'b0;
      sb_q.delete();
      for (int i = 0; i < SB_DEPTH; i++) begin
        e = '0;
        e.clr = (i == 0);
        sb_q.push_back(e);
      end
    end else begin
      e       = '0;
      iss     = enable && ch_en[m_slot];
      e.valid = iss;
      e.ch    = m_slot;
      m_fs    = iss && (m_slot == 0);
      if (iss) begin
        sum     = m_acc[m_slot] + m_off[m_slot];
        m_theta = QD'(sum >> SHIFT);
        e.s     = lut_sin(m_theta);
        e.c     = lut_cos(m_theta);
        m_acc[m_slot] = m_acc[m_slot] + m_freq[m_slot];
      end
      if (cfg_we) begin
        case (cfg_sel)
          CFG_FREQ: m_freq[cfg_ch] = cfg_data;
          CFG_OFFS: m_off[cfg_ch]  = cfg_data;
          CFG_CLR:  m_acc[cfg_ch]  = '0;
          default:  ;
        endcase
      end
      if (enable) m_slot = m_slot + CH_W'(1);
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t                 e;
    logic signed [DW-1:0] h_sin, h_cos;
    if (m_live) begin
      check("theta", 32'(theta), 32'(m_theta));
      check("frame_sync", 32'(frame_sync), 32'(m_fs));
      if (sb_q.size() >= SB_DEPTH) begin
        e = sb_q.pop_front();
        if (e.clr)   begin h_sin = '0;  h_cos = '0;  end
        if (e.valid) begin h_sin = e.s; h_cos = e.c; end
        check("sb_valid", 32'(out_valid), 32'(e.valid));
        if (e.valid) check("sb_ch", 32'(out_ch), 32'(e.ch));
        check("sb_sin", 32'(out_sin), 32'(h_sin));
        check("sb_cos", 32'(out_cos), 32'(h_cos));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input cfg_sel_t sel, input logic [PW-1:0] d);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = d;
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  // Step to the next clock where slot 0 was issued; bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!frame_sync && n < 4 * NCH);
    check("wait_frame_sync", 32'(frame_sync), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [QD-1:0] ch0_seq [5] = '{11'd0, 11'd512, 11'd1024, 11'd1536, 11'd0};
  logic [QD-1:0] t_prev, t_exp;
  int            n_val;

  initial begin
    arst = 1'b1; enable = 1'b0; ch_en = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = CFG_FREQ; cfg_data = '0;
    cyc(3);
    check("rst_theta",      32'(theta),      32'd0);
    check("rst_frame_sync", 32'(frame_sync), 32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_ch",     32'(out_ch),     32'd0);
    check("rst_out_sin",    32'(out_sin),    32'd0);
    check("rst_out_cos",    32'(out_cos),    32'd0);

    // All channels, freq 0: first valid four clocks after the first issue.
    arst = 1'b0; ch_en = '1; enable = 1'b1;
    cyc(4);
    check("first_valid_early", 32'(out_valid), 32'd0);
    for (int k = 0; k < NCH; k++) begin
      cyc(1);
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_ch",    32'(out_ch),    32'(k));
      check("rr_cos",   32'(out_cos),   32'd32767);
    end

    // Channel 0 at a quarter turn per issue.
    cfg_write(0, CFG_FREQ, 32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      wait_fs();
      check("ch0_theta_seq", 32'(theta), 32'(ch0_seq[i]));
    end
    wait_fs();
    check("ch0_theta_90", 32'(theta), 32'd512);
    cyc(4);
    check("ch0_90_valid", 32'(out_valid), 32'd1);
    check("ch0_90_ch",    32'(out_ch),    32'd0);
    check("ch0_90_sin",   32'(out_sin),   32'd32767);
    check("ch0_90_cos",   32'(out_cos),   32'd0);

    // Only channels 1 and 3 enabled for ten frames.
    cfg_write(2, CFG_FREQ, 32'h0100_0000);
    wait_fs();
    t_prev = theta;
    ch_en  = 4'b1010;
    n_val  = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (i >= 8 && i < 16) begin
        if (out_valid) begin
          n_val++;
          check("odd_ch_only", 32'(out_ch[0]), 32'd1);
        end
      end
    end
    check("valid_per_2_frames", 32'(n_val), 32'd4);
    ch_en = '1;
    wait_fs();
    t_exp = t_prev + 11'd512;
    check("ch0_acc_held", 32'(theta), 32'(t_exp));

    // Freq write and clear on channel 1 in its own issue cycle.
    cfg_write(1, CFG_OFFS, 32'h0040_0000);
    cfg_write(1, CFG_FREQ, 32'h1000_0000);
    wait_fs();
    cfg_write(1, CFG_FREQ, 32'h2000_0000);
    t_prev = theta;
    wait_fs(); cyc(1);
    t_exp = t_prev + 11'd128;
    check("ch1_old_freq", 32'(theta), 32'(t_exp));
    wait_fs(); cyc(1);
    t_exp = t_exp + 11'd256;
    check("ch1_new_freq", 32'(theta), 32'(t_exp));
    wait_fs();
    cfg_write(1, CFG_CLR, '0);
    t_exp = t_exp + 11'd256;
    check("ch1_clr_uses_old", 32'(theta), 32'(t_exp));
    wait_fs(); cyc(1);
    check("ch1_after_clr", 32'(theta), 32'd2);

    // Drop enable after three issues of a frame.
    wait_fs(); cyc(2);
    enable = 1'b0;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_ch",    32'(out_ch),    32'(k));
      cyc(1);
    end
    for (int k = 0; k < 4; k++) begin
      check("drained_valid", 32'(out_valid), 32'd0);
      cyc(1);
    end
    enable = 1'b1;
    cyc(1);
    check("resume_slot3_fs", 32'(frame_sync), 32'd0);
    cyc(1);
    check("resume_slot0_fs", 32'(frame_sync), 32'd1);

    // Reset with the pipeline full.
    cyc(2);
    arst = 1'b1;
    cyc(1);
    check("mid_rst_valid", 32'(out_valid),  32'd0);
    check("mid_rst_ch",    32'(out_ch),     32'd0);
    check("mid_rst_sin",   32'(out_sin),    32'd0);
    check("mid_rst_cos",   32'(out_cos),    32'd0);
    check("mid_rst_theta", 32'(theta),      32'd0);
    check("mid_rst_fs",    32'(frame_sync), 32'd0);
    arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    cyc(1);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_ch",    32'(out_ch),    32'd0);
    check("post_rst_cos",   32'(out_cos),   32'd32767);

    // Random traffic, checked by the scoreboard.
    for (int i = 0; i < 64; i++) begin
      ch_en    = NCH'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      cfg_we   = $urandom_range(0, 1) == 1;
      cfg_ch   = CH_W'($urandom);
      cfg_sel  = 2'($urandom);
      cfg_data = $urandom;
      cyc(1);
    end
    cfg_we = 1'b0;
    enable = 1'b1;
    cyc(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
